// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- signal bundle between the pipeline and the hazard controller.
//
// Decode side : id_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, reg_wen_i
// Execute side: ex_jump_en_i, ex_jump_addr_i
// Write-back  : wb_wen_i, wb_rd_addr_i
// Controls    : hold_o, flush_o, jump_en_o, jump_addr_o
// Status      : pending_o (outstanding-write scoreboard), stall_cnt_o (hold cycles)
//
// master modport: the pipeline (drives *_i, observes *_o)
// slave  modport: hazard_ctrl  (observes *_i, drives *_o)
interface hazard_ctrl_if;
   logic        id_valid_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic [4:0]  rd_addr_i;
   logic        reg_wen_i;
   logic        ex_jump_en_i;
   logic [31:0] ex_jump_addr_i;
   logic        wb_wen_i;
   logic [4:0]  wb_rd_addr_i;
   logic        hold_o;
   logic        flush_o;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic [31:0] pending_o;
   logic [31:0] stall_cnt_o;

   modport master (
      output id_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, reg_wen_i,
             ex_jump_en_i, ex_jump_addr_i, wb_wen_i, wb_rd_addr_i,
      input  hold_o, flush_o, jump_en_o, jump_addr_o, pending_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, reg_wen_i,
             ex_jump_en_i, ex_jump_addr_i, wb_wen_i, wb_rd_addr_i,
      output hold_o, flush_o, jump_en_o, jump_addr_o, pending_o, stall_cnt_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller.
//
// Tracks outstanding register writes in a 32-bit scoreboard, stalls decode on
// read-after-write hazards, passes taken jumps through to the PC and flushes
// if_id/id_ex for FLUSH_CYCLES cycles starting in the jump cycle.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : hazard_ctrl_if.slave (decode, execute jump, write-back inputs;
//          hold/flush/jump controls, scoreboard and stall counter outputs)
//
// Parameter FLUSH_CYCLES: flush length after a taken jump, legal 1..7.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);

   typedef enum logic {
      S_IDLE,
      S_FLUSH
   } state_t;

   localparam logic [2:0] LP_RELOAD = 3'(FLUSH_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nxt;
   logic [31:0] r_pending;
   logic [31:0] w_pending_nxt;
   logic [31:0] r_stall_cnt;

   logic [31:0] w_wb_mask;
   logic [31:0] w_issue_mask;
   logic [31:0] w_eff;
   logic        w_hazard;
   logic        w_hold;
   logic        w_flush;
   logic        w_issue;

   // Same-cycle write-back is forwarded by the register file, so its bit must
   // not cause a stall.
   always_comb begin
      w_wb_mask = '0;
      if (bus.wb_wen_i && (bus.wb_rd_addr_i != '0))
         w_wb_mask = 32'd1 << bus.wb_rd_addr_i;
   end

   assign w_eff    = r_pending & ~w_wb_mask;
   assign w_hazard = bus.id_valid_i &
                     (((bus.rs1_addr_i != '0) & w_eff[bus.rs1_addr_i]) |
                      ((bus.rs2_addr_i != '0) & w_eff[bus.rs2_addr_i]));
   assign w_hold   = ~rst & w_hazard & ~w_flush;

   assign w_issue = bus.id_valid_i & bus.reg_wen_i & (bus.rd_addr_i != '0) &
                    ~w_hold & ~w_flush;

   always_comb begin
      w_issue_mask = '0;
      if (w_issue)
         w_issue_mask = 32'd1 << bus.rd_addr_i;
   end

   // Clear first, then set: an issue and write-back to the same register
   // leave the bit set. Bit 0 is never tracked.
   assign w_pending_nxt = ((r_pending & ~w_wb_mask) | w_issue_mask) & ~32'd1;

   // Flush FSM. The IDLE->FLUSH transition already covers the jump cycle, so
   // FLUSH leaves once the count would reach zero; this yields exactly
   // FLUSH_CYCLES flush cycles including the jump cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_flush     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_flush = bus.ex_jump_en_i;
            if (bus.ex_jump_en_i && (FLUSH_CYCLES > 1)) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = LP_RELOAD;
            end
         end
         S_FLUSH: begin
            w_flush = 1'b1;
            if (bus.ex_jump_en_i) begin
               w_cnt_nxt = LP_RELOAD;
            end else if (r_cnt <= 3'd1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      if (rst)
         w_flush = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_pending   <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
         if (w_hold)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.hold_o      = w_hold;
   assign bus.flush_o     = w_flush;
   assign bus.jump_en_o   = ~rst & bus.ex_jump_en_i;
   assign bus.jump_addr_o = (~rst & bus.ex_jump_en_i) ? bus.ex_jump_addr_i : '0;
   assign bus.pending_o   = r_pending;
   assign bus.stall_cnt_o = r_stall_cnt;

endmodule
